wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//  Shares the single GPR write port of the register file among N_REQ writeback
//  sources (ALU commit, load return, mul/div completion). Round-robin, one grant
//  per cycle, registered output stage driving the regfile wen/wreg/wdata pins.
//  Sits between the writeback sources and the regfile. The regfile's same-cycle
//  write->read bypass covers the registered write.
// PARAMETERS
//  N_REQ   3   number of writeback requesters (2..8)
//  IDW     2   width of grant_id, >= clog2(N_REQ)
// PORTS
//  clk          in   1          clock, all state updates on posedge
//  reset        in   1          asynchronous, active-high reset
//  rf_block     in   1          1 = grant nothing this cycle (exception/flush commit)
//  req_valid    in   N_REQ      requester i has a pending write
//  req_wreg     in   5*N_REQ    dest reg of requester i, bits [5i+4:5i]
//  req_wdata    in   32*N_REQ   data of requester i, bits [32i+31:32i]
//  req_ready    out  N_REQ      one-hot/zero; requester i's write accepted this cycle
//  rf_wen       out  1          regfile write enable (registered)
//  rf_wreg      out  5          regfile write address (registered)
//  rf_wdata     out  32         regfile write data (registered)
//  grant_id     out  IDW        index of requester whose write is on rf_* (registered)
// BEHAVIOUR
//  - Reset (async, reset=1): rf_wen=0, rf_wreg=0, rf_wdata=0, grant_id=0,
//    rr_ptr=0; req_ready=0 while reset is high. Reset mid-transfer drops the
//    pending output write; requesters re-present after reset.
//  - Handshake: valid/ready. Transfer when req_valid[i] && req_ready[i]. Once
//    asserted, req_valid[i], req_wreg, req_wdata stay stable until accepted.
//  - req_ready is combinational from req_valid, rr_ptr, rf_block. No
//    combinational path from any req_wdata/req_wreg to req_ready.
//  - Arbitration: search order starts at rr_ptr, wraps mod N_REQ. The first i
//    with req_valid[i]=1 gets req_ready[i]=1. At most one ready bit is set.
//  - rf_block=1: req_ready=0, no transfer, rr_ptr unchanged. rf_wen=0 next cycle.
//  - Pointer: on transfer by i, rr_ptr <= (i+1) mod N_REQ (i=N_REQ-1 wraps to 0).
//    With no transfer, rr_ptr holds.
//  - Output stage, latency 1: a transfer in cycle t drives rf_* in cycle t+1:
//    rf_wreg=req_wreg[i], rf_wdata=req_wdata[i], grant_id=i.
//    rf_wen=1 only if req_wreg[i]!=0. A write to $0 is accepted but suppressed.
//  - No transfer in cycle t: rf_wen=0 in t+1. rf_wreg, rf_wdata and grant_id
//    hold their last values.
//  - Port never back-pressures: the output register loads every cycle, so
//    sustained throughput is one write per cycle.
//  - Same dest from two requesters: written in grant order. The later grant wins
//    in the regfile. No merging, no reordering.
//  - Fairness: a continuously valid requester is granted within N_REQ cycles
//    with rf_block=0.
// TESTING
//  1 reset=1 pulse mid-cycle with a pending write -> rf_wen=0, req_ready=0
//    immediately; after release rr_ptr=0.
//  2 only req1 valid, wreg=5, wdata=32'hDEADBEEF -> req_ready=3'b010 in cycle t;
//    t+1: rf_wen=1, rf_wreg=5, rf_wdata=DEADBEEF, grant_id=1.
//  3 all 3 valid for 6 cycles, rr_ptr=0 -> grants 0,1,2,0,1,2; rf_wen=1 every
//    cycle from t+1.
//  4 req0 valid, wreg=0, wdata=1 -> accepted (req_ready[0]=1); next cycle rf_wen=0,
//    grant_id=0.
//  5 rf_block=1 for 3 cycles with req2 valid -> req_ready=0, rf_wen=0, rr_ptr held;
//    granted first cycle after rf_block=0.
//  6 req0, req2 both write wreg=7 (data 1, 2), rr_ptr=2 -> rf_wdata=2 then 1;
//    regfile ends with $7=1.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing the single regfile write port among N_REQ writeback sources.
// One grant per cycle; the accepted write is registered onto the rf_* pins one cycle later.
module wb_port_arbiter #(
  parameter int N_REQ = 3,
  parameter int IDW   = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_rf_block,
  input  logic [N_REQ-1:0]      i_req_valid,
  input  logic [5*N_REQ-1:0]    i_req_wreg,
  input  logic [32*N_REQ-1:0]   i_req_wdata,
  output logic [N_REQ-1:0]      o_req_ready,
  output logic                  o_rf_wen,
  output logic [4:0]            o_rf_wreg,
  output logic [31:0]           o_rf_wdata,
  output logic [IDW-1:0]        o_grant_id
);

  logic [IDW-1:0]   r_rr_ptr;
  logic             r_rf_wen;
  logic [4:0]       r_rf_wreg;
  logic [31:0]      r_rf_wdata;
  logic [IDW-1:0]   r_grant_id;

  logic             w_found;
  logic             w_xfer;
  logic [N_REQ-1:0] w_ready;
  logic [IDW-1:0]   w_gid;
  logic [IDW-1:0]   w_next_ptr;
  logic [4:0]       w_wreg;
  logic [31:0]      w_wdata;
  int               w_idx;

  // Scan starts at the pointer and wraps; only req_valid/pointer/block feed the ready path.
  always_comb begin
    w_found    = 1'b0;
    w_ready    = '0;
    w_gid      = '0;
    w_next_ptr = r_rr_ptr;
    w_wreg     = '0;
    w_wdata    = '0;
    w_idx      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
      if (!w_found && i_req_valid[w_idx]) begin
        w_found        = 1'b1;
        w_ready[w_idx] = 1'b1;
        w_gid          = IDW'(w_idx);
        w_next_ptr     = (w_idx == N_REQ - 1) ? '0 : IDW'(w_idx + 1);
        w_wreg         = i_req_wreg[5*w_idx +: 5];
        w_wdata        = i_req_wdata[32*w_idx +: 32];
      end
    end
    if (i_rf_block || i_reset) begin
      w_found = 1'b0;
      w_ready = '0;
    end
  end

  assign w_xfer = w_found;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rr_ptr   <= '0;
      r_rf_wen   <= 1'b0;
      r_rf_wreg  <= '0;
      r_rf_wdata <= '0;
      r_grant_id <= '0;
    end else begin
      // A write to $0 is still accepted, just never enabled on the port.
      r_rf_wen <= w_xfer && (w_wreg != 5'd0);
      if (w_xfer) begin
        r_rr_ptr   <= w_next_ptr;
        r_rf_wreg  <= w_wreg;
        r_rf_wdata <= w_wdata;
        r_grant_id <= w_gid;
      end
    end
  end

  assign o_req_ready = w_ready;
  assign o_rf_wen    = r_rf_wen;
  assign o_rf_wreg   = r_rf_wreg;
  assign o_rf_wdata  = r_rf_wdata;
  assign o_grant_id  = r_grant_id;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed vector table, hand-written reset sequence,
// and a randomized run scored against a request-queue model of the round-robin rules.
module tb_wb_port_arbiter;
  localparam int N = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          blk;
  logic [2:0]    valid;
  logic [14:0]   wreg;
  logic [95:0]   wdata;
  logic [2:0]    ready;
  logic          rf_wen;
  logic [4:0]    rf_wreg;
  logic [31:0]   rf_wdata;
  logic [1:0]    gid;

  int total = 0;
  int bad   = 0;
  logic [31:0] rf_shadow [32];

  always #5 clk = ~clk;

  wb_port_arbiter #(.N_REQ(3), .IDW(2)) dut (
    .i_clk(clk), .i_reset(rst), .i_rf_block(blk), .i_req_valid(valid),
    .i_req_wreg(wreg), .i_req_wdata(wdata), .o_req_ready(ready),
    .o_rf_wen(rf_wen), .o_rf_wreg(rf_wreg), .o_rf_wdata(rf_wdata), .o_grant_id(gid)
  );

  always @(posedge clk) if (rf_wen) rf_shadow[rf_wreg] <= rf_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  valid;
    logic        blk;
    logic [14:0] wreg;
    logic [95:0] wdata;
    logic [2:0]  ready;
    logic        wen;
    logic [4:0]  ewreg;
    logic [31:0] edata;
    logic [1:0]  egid;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [2:0] v, input logic b, input logic [14:0] wr, input logic [95:0] wd,
                     input logic [2:0] rdy, input logic wen, input logic [4:0] ewr,
                     input logic [31:0] ed, input logic [1:0] eg);
    vec_t e;
    e.valid = v; e.blk = b; e.wreg = wr; e.wdata = wd; e.ready = rdy;
    e.wen = wen; e.ewreg = ewr; e.edata = ed; e.egid = eg;
    tbl.push_back(e);
  endtask

  // Called at a negedge: drive, check ready, then check the registered result at the next negedge.
  task automatic run_vec(input vec_t v, input int n);
    valid = v.valid; blk = v.blk; wreg = v.wreg; wdata = v.wdata;
    #1;
    chk($sformatf("v%0d ready", n), 32'(ready), 32'(v.ready));
    @(negedge clk);
    chk($sformatf("v%0d wen", n), 32'(rf_wen), 32'(v.wen));
    chk($sformatf("v%0d wreg", n), 32'(rf_wreg), 32'(v.ewreg));
    chk($sformatf("v%0d wdata", n), rf_wdata, v.edata);
    chk($sformatf("v%0d gid", n), 32'(gid), 32'(v.egid));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    valid = '0; blk = 1'b0; wreg = '0; wdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Random-phase model state
  bit          pv [N];
  logic [4:0]  pw [N];
  logic [31:0] pd [N];
  int          wait_c [N];

  initial begin
    int m_ptr, g;
    logic       e_wen;
    logic [4:0] e_wreg;
    logic [31:0] e_data;
    logic [1:0] e_gid;
    logic [2:0] e_ready;

    for (int i = 0; i < 32; i++) rf_shadow[i] = '0;
    rst = 1'b1; blk = 1'b0; valid = 3'b111; wreg = '1; wdata = '1;
    @(negedge clk);
    chk("reset ready", 32'(ready), 32'd0);
    chk("reset wen", 32'(rf_wen), 32'd0);
    chk("reset wreg", 32'(rf_wreg), 32'd0);
    chk("reset wdata", rf_wdata, 32'd0);
    chk("reset gid", 32'(gid), 32'd0);
    do_reset();

    // all valid from pointer 0: 0,1,2,0,1,2
    for (int r = 0; r < 6; r++)
      add(3'b111, 1'b0, {5'd3, 5'd2, 5'd1}, {32'h200, 32'h100, 32'h0AA},
          3'(1 << (r % 3)), 1'b1, 5'((r % 3) + 1),
          (r % 3 == 0) ? 32'h0AA : (r % 3 == 1) ? 32'h100 : 32'h200, 2'(r % 3));
    add(3'b010, 1'b0, {5'd0, 5'd5, 5'd0}, {32'h0, 32'hDEADBEEF, 32'h0},
        3'b010, 1'b1, 5'd5, 32'hDEADBEEF, 2'd1);
    add(3'b001, 1'b0, {5'd0, 5'd0, 5'd0}, {32'h0, 32'h0, 32'h1},
        3'b001, 1'b0, 5'd0, 32'h1, 2'd0);
    for (int r = 0; r < 3; r++)
      add(3'b100, 1'b1, {5'd9, 5'd0, 5'd0}, {32'h55, 32'h0, 32'h0},
          3'b000, 1'b0, 5'd0, 32'h1, 2'd0);
    add(3'b100, 1'b0, {5'd9, 5'd0, 5'd0}, {32'h55, 32'h0, 32'h0},
        3'b100, 1'b1, 5'd9, 32'h55, 2'd2);
    add(3'b010, 1'b0, {5'd0, 5'd3, 5'd0}, {32'h0, 32'h33, 32'h0},
        3'b010, 1'b1, 5'd3, 32'h33, 2'd1);
    add(3'b101, 1'b0, {5'd7, 5'd0, 5'd7}, {32'h2, 32'h0, 32'h1},
        3'b100, 1'b1, 5'd7, 32'h2, 2'd2);
    add(3'b001, 1'b0, {5'd7, 5'd0, 5'd7}, {32'h2, 32'h0, 32'h1},
        3'b001, 1'b1, 5'd7, 32'h1, 2'd0);
    add(3'b000, 1'b0, '0, '0, 3'b000, 1'b0, 5'd7, 32'h1, 2'd0);

    foreach (tbl[k]) run_vec(tbl[k], k);
    chk("same-dest regfile $7", rf_shadow[7], 32'h1);

    // Reset mid-cycle with a write on the port and a pending request
    valid = 3'b010; blk = 1'b0; wreg = {5'd0, 5'd4, 5'd0}; wdata = {32'h0, 32'h44, 32'h0};
    #1;
    chk("t1 pre ready", 32'(ready), 32'b010);
    @(posedge clk); #1;
    chk("t1 pre wen", 32'(rf_wen), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t1 async wen", 32'(rf_wen), 32'd0);
    chk("t1 async ready", 32'(ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    valid = 3'b111;
    #1;
    chk("t1 ptr back to 0", 32'(ready), 32'b001);
    @(negedge clk);
    chk("t1 gid", 32'(gid), 32'd0);

    // Randomized phase against the request-queue model
    do_reset();
    m_ptr = 0; e_wen = 0; e_wreg = 0; e_data = 0; e_gid = 0;
    for (int i = 0; i < N; i++) begin pv[i] = 0; pw[i] = 0; pd[i] = 0; wait_c[i] = 0; end
    for (int cyc = 0; cyc < 400; cyc++) begin
      chk("rnd wen", 32'(rf_wen), 32'(e_wen));
      chk("rnd wreg", 32'(rf_wreg), 32'(e_wreg));
      chk("rnd wdata", rf_wdata, e_data);
      chk("rnd gid", 32'(gid), 32'(e_gid));
      for (int i = 0; i < N; i++)
        if (!pv[i] && $urandom_range(0, 1) == 1) begin
          pv[i] = 1; pw[i] = 5'($urandom_range(0, 31)); pd[i] = $urandom; wait_c[i] = 0;
        end
      blk = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < N; i++) begin
        valid[i] = pv[i];
        wreg[5*i +: 5] = pv[i] ? pw[i] : 5'($urandom);
        wdata[32*i +: 32] = pv[i] ? pd[i] : $urandom;
      end
      g = -1;
      if (!blk)
        for (int k = 0; k < N; k++)
          if (g < 0 && pv[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      e_ready = (g >= 0) ? 3'(1 << g) : 3'b000;
      #1;
      chk("rnd ready", 32'(ready), 32'(e_ready));
      for (int i = 0; i < N; i++) if (pv[i] && !blk) wait_c[i]++;
      if (g >= 0) begin
        chk("rnd fairness", 32'(wait_c[g] <= N), 32'd1);
        e_wen = (pw[g] != 0); e_wreg = pw[g]; e_data = pd[g]; e_gid = 2'(g);
        m_ptr = (g + 1) % N;
        pv[g] = 0;
      end else begin
        e_wen = 0;
      end
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected finish");
    $fatal(1, "timeout");
  end

endmodule
